// File: rtl/acc_offload_pkg.sv
// Shared constants and helpers for the accelerator offload tracker.
// RegAddrWidth : width of a core register index (x0..x31).
// OpWidth      : width of an offloaded instruction word.
// resv_id()    : the reserved "no write-back" transaction ID (all ones).
package acc_offload_pkg;

    localparam int RegAddrWidth = 5;
    localparam int OpWidth      = 32;

    function automatic int unsigned resv_id(input int unsigned id_width);
        return (32'd1 << id_width) - 32'd1;
    endfunction

endpackage

// File: rtl/acc_stream_reg.sv
// One-entry, full-throughput valid/ready register.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i downstream handshake, out_data_o payload
// Handshake: a transfer happens on a rising edge where valid && ready.
// Valid never drops without a transfer and payload is stable while
// valid is high and ready is low.
module acc_stream_reg #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic valid_q;
    T     data_q;

    // Accepting while full is allowed when the held entry leaves this cycle.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/acc_offload_tracker.sv
// Upstream stage of the accelerator Q/P bus.
// Accepts offloads from the core, allocates transaction IDs, issues them
// on the Q channel through a stream register, matches P responses back to
// destination registers and returns them as write-backs. A per-register
// busy scoreboard lets the core stall on RAW; WAW is stalled here.
// Ports:
//   req_*      core offload request (valid/ready)
//   acc_q_*    Q channel to the accelerator (valid/ready)
//   acc_p_*    P channel from the accelerator (valid/ready)
//   wb_*       write-back to the core (valid/ready)
//   busy_o     scoreboard of registers with a result outstanding
//   outstanding_o number of allocated IDs
//   stray_o    one-cycle pulse after a response with no matching ID
module acc_offload_tracker
    import acc_offload_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AccAddrWidth = 4,
    parameter int IdWidth      = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AccAddrWidth-1:0] req_addr_i,
    input  logic [OpWidth-1:0]      req_op_i,
    input  logic [DataWidth-1:0]    req_arga_i,
    input  logic [DataWidth-1:0]    req_argb_i,
    input  logic [DataWidth-1:0]    req_argc_i,
    input  logic [RegAddrWidth-1:0] req_rd_i,
    input  logic                    req_wb_i,
    output logic [AccAddrWidth-1:0] acc_q_addr_o,
    output logic [OpWidth-1:0]      acc_q_data_op_o,
    output logic [DataWidth-1:0]    acc_q_data_arga_o,
    output logic [DataWidth-1:0]    acc_q_data_argb_o,
    output logic [DataWidth-1:0]    acc_q_data_argc_o,
    output logic [IdWidth-1:0]      acc_q_id_o,
    output logic                    acc_q_valid_o,
    input  logic                    acc_q_ready_i,
    input  logic [DataWidth-1:0]    acc_p_data_i,
    input  logic [IdWidth-1:0]      acc_p_id_i,
    input  logic                    acc_p_error_i,
    input  logic                    acc_p_valid_i,
    output logic                    acc_p_ready_o,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [RegAddrWidth-1:0] wb_rd_o,
    output logic [DataWidth-1:0]    wb_data_o,
    output logic                    wb_error_o,
    output logic [31:0]             busy_o,
    output logic [IdWidth-1:0]      outstanding_o,
    output logic                    stray_o
);

    localparam int NumIds   = (2 ** IdWidth) - 1;
    localparam int IdSlots  = 2 ** IdWidth;
    localparam logic [IdWidth-1:0] ResvId = IdWidth'(resv_id(IdWidth));

    typedef struct packed {
        logic [AccAddrWidth-1:0] addr;
        logic [OpWidth-1:0]      op;
        logic [DataWidth-1:0]    arga;
        logic [DataWidth-1:0]    argb;
        logic [DataWidth-1:0]    argc;
        logic [IdWidth-1:0]      id;
    } q_payload_t;

    typedef struct packed {
        logic [RegAddrWidth-1:0] rd;
        logic [DataWidth-1:0]    data;
        logic                    error;
        logic [IdWidth-1:0]      id;
    } wb_payload_t;

    logic [NumIds-1:0]       free_q, free_d;
    logic [RegAddrWidth-1:0] id_rd_q [IdSlots];
    logic [31:0]             busy_q, busy_d;
    logic [IdWidth-1:0]      outstanding_q, outstanding_d;
    logic                    stray_q, stray_d;

    logic [IdWidth-1:0] alloc_id;
    logic               id_avail, needs_id, hazard_ok, alloc, rel;
    logic               q_in_ready, wb_in_ready, wb_in_valid, p_known;
    logic [IdSlots-1:0] free_ext;
    q_payload_t         q_in, q_out;
    wb_payload_t        wb_in, wb_out;

    // Lowest-index free ID from the start-of-cycle free list, so a release
    // in the same cycle can never be handed out again immediately.
    always_comb begin
        alloc_id = '0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_id = IdWidth'(i);
        end
    end

    assign id_avail  = |free_q;
    assign needs_id  = req_wb_i && (req_rd_i != '0);
    assign hazard_ok = !req_wb_i || (id_avail && ((req_rd_i == '0) || !busy_q[req_rd_i]));
    assign req_ready_o = q_in_ready && hazard_ok;
    assign alloc       = req_valid_i && req_ready_o && needs_id;

    assign q_in = '{addr: req_addr_i, op: req_op_i, arga: req_arga_i, argb: req_argb_i,
                    argc: req_argc_i, id: (needs_id ? alloc_id : ResvId)};

    acc_stream_reg #(.T(q_payload_t)) u_q_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (req_valid_i && hazard_ok),
        .in_ready_o  (q_in_ready),
        .in_data_i   (q_in),
        .out_valid_o (acc_q_valid_o),
        .out_ready_i (acc_q_ready_i),
        .out_data_o  (q_out)
    );

    assign acc_q_addr_o      = q_out.addr;
    assign acc_q_data_op_o   = q_out.op;
    assign acc_q_data_arga_o = q_out.arga;
    assign acc_q_data_argb_o = q_out.argb;
    assign acc_q_data_argc_o = q_out.argc;
    assign acc_q_id_o        = q_out.id;

    // The reserved ID maps onto a permanently-free extra slot, so a single
    // lookup classifies both reserved and unallocated IDs as stray.
    assign free_ext      = {1'b1, free_q};
    assign p_known       = !free_ext[acc_p_id_i];
    assign wb_in_valid   = acc_p_valid_i && p_known;
    assign acc_p_ready_o = wb_in_ready;
    assign stray_d       = acc_p_valid_i && acc_p_ready_o && !p_known;

    assign wb_in = '{rd: id_rd_q[acc_p_id_i], data: acc_p_data_i,
                     error: acc_p_error_i, id: acc_p_id_i};

    acc_stream_reg #(.T(wb_payload_t)) u_wb_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (wb_in_valid),
        .in_ready_o  (wb_in_ready),
        .in_data_i   (wb_in),
        .out_valid_o (wb_valid_o),
        .out_ready_i (wb_ready_i),
        .out_data_o  (wb_out)
    );

    assign wb_rd_o    = wb_out.rd;
    assign wb_data_o  = wb_out.data;
    assign wb_error_o = wb_out.error;
    assign rel        = wb_valid_o && wb_ready_i;

    // Allocation and release touch different IDs and different registers,
    // so applying both in the same cycle never conflicts.
    always_comb begin
        free_d = free_q;
        busy_d = busy_q;
        if (alloc) begin
            free_d[alloc_id] = 1'b0;
            busy_d[req_rd_i] = 1'b1;
        end
        if (rel) begin
            free_d[wb_out.id]  = 1'b1;
            busy_d[wb_out.rd]  = 1'b0;
        end
        busy_d[0] = 1'b0;
        outstanding_d = outstanding_q + {{(IdWidth-1){1'b0}}, alloc}
                                      - {{(IdWidth-1){1'b0}}, rel};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q        <= '1;
            busy_q        <= '0;
            outstanding_q <= '0;
            stray_q       <= 1'b0;
            for (int i = 0; i < IdSlots; i++) id_rd_q[i] <= '0;
        end else begin
            free_q        <= free_d;
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            stray_q       <= stray_d;
            if (alloc) id_rd_q[alloc_id] <= req_rd_i;
        end
    end

    assign busy_o        = busy_q;
    assign outstanding_o = outstanding_q;
    assign stray_o       = stray_q;

endmodule

// File: tb/tb_acc_offload_tracker.sv
// Directed bench for acc_offload_tracker with Q and write-back scoreboards.
module tb_acc_offload_tracker;

  localparam logic [2:0] RESV = 3'd7;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  req_addr_i = '0;
  logic [31:0] req_op_i = '0, req_arga_i = '0, req_argb_i = '0, req_argc_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        req_wb_i = 1'b0;
  logic [3:0]  acc_q_addr_o;
  logic [31:0] acc_q_data_op_o, acc_q_data_arga_o, acc_q_data_argb_o, acc_q_data_argc_o;
  logic [2:0]  acc_q_id_o;
  logic        acc_q_valid_o;
  logic        acc_q_ready_i = 1'b1;
  logic [31:0] acc_p_data_i = '0;
  logic [2:0]  acc_p_id_i = '0;
  logic        acc_p_error_i = 1'b0;
  logic        acc_p_valid_i = 1'b0;
  logic        acc_p_ready_o;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_error_o;
  logic [31:0] busy_o;
  logic [2:0]  outstanding_o;
  logic        stray_o;

  acc_offload_tracker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_op_i(req_op_i), .req_arga_i(req_arga_i), .req_argb_i(req_argb_i),
    .req_argc_i(req_argc_i), .req_rd_i(req_rd_i), .req_wb_i(req_wb_i),
    .acc_q_addr_o(acc_q_addr_o), .acc_q_data_op_o(acc_q_data_op_o),
    .acc_q_data_arga_o(acc_q_data_arga_o), .acc_q_data_argb_o(acc_q_data_argb_o),
    .acc_q_data_argc_o(acc_q_data_argc_o), .acc_q_id_o(acc_q_id_o),
    .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
    .acc_p_data_i(acc_p_data_i), .acc_p_id_i(acc_p_id_i), .acc_p_error_i(acc_p_error_i),
    .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .wb_error_o(wb_error_o), .busy_o(busy_o),
    .outstanding_o(outstanding_o), .stray_o(stray_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [159:0] q_exp[$];
  logic [159:0] wb_exp[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] q_obs();
    return {25'd0, acc_q_addr_o, acc_q_data_op_o, acc_q_data_arga_o,
            acc_q_data_argb_o, acc_q_data_argc_o, acc_q_id_o};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // driver: offload one request, expecting the given Q id
  task automatic send(input logic [4:0] rd, input logic wb, input logic [2:0] exp_id);
    int n = 0;
    req_valid_i = 1'b1;
    req_addr_i  = 4'($urandom_range(0, 15));
    req_op_i    = $urandom();
    req_arga_i  = $urandom();
    req_argb_i  = $urandom();
    req_argc_i  = $urandom();
    req_rd_i    = rd;
    req_wb_i    = wb;
    #1;
    while (!req_ready_o && n < 50) begin
      tick(1);
      n++;
    end
    if (!req_ready_o) begin
      chk("send_timeout", 160'd0, 160'd1);
      req_valid_i = 1'b0;
      return;
    end
    q_exp.push_back({25'd0, req_addr_i, req_op_i, req_arga_i, req_argb_i, req_argc_i, exp_id});
    tick(1);
    req_valid_i = 1'b0;
  endtask

  // driver: one P response; known responses must come back as write-backs
  task automatic respond(input logic [2:0] id, input logic [31:0] data, input logic err,
                         input logic [4:0] exp_rd, input logic known);
    int n = 0;
    acc_p_valid_i = 1'b1;
    acc_p_id_i    = id;
    acc_p_data_i  = data;
    acc_p_error_i = err;
    #1;
    while (!acc_p_ready_o && n < 50) begin
      tick(1);
      n++;
    end
    if (!acc_p_ready_o) begin
      chk("resp_timeout", 160'd0, 160'd1);
      acc_p_valid_i = 1'b0;
      return;
    end
    if (known) wb_exp.push_back({122'd0, exp_rd, data, err});
    tick(1);
    acc_p_valid_i = 1'b0;
  endtask

  // scoreboard: compare every Q and write-back transfer against the queues
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (acc_q_valid_o && acc_q_ready_i) begin
        if (q_exp.size() == 0) chk("q_unexpected", 160'd1, 160'd0);
        else chk("q_payload", q_obs(), q_exp.pop_front());
      end
      if (wb_valid_o && wb_ready_i) begin
        if (wb_exp.size() == 0) chk("wb_unexpected", 160'd1, 160'd0);
        else chk("wb_payload", {122'd0, wb_rd_o, wb_data_o, wb_error_o}, wb_exp.pop_front());
      end
    end
  end

  initial begin
    // reset
    tick(3);
    chk("rst_q_valid", 160'(acc_q_valid_o), 160'd0);
    chk("rst_wb_valid", 160'(wb_valid_o), 160'd0);
    chk("rst_busy", 160'(busy_o), 160'd0);
    rst_ni = 1'b1;
    tick(1);
    chk("rst_outstanding", 160'(outstanding_o), 160'd0);
    chk("rst_stray", 160'(stray_o), 160'd0);
    chk("rst_q_payload", q_obs(), 160'd0);

    // back-to-back write-back requests rd 5,6,7
    send(5'd5, 1'b1, 3'd0);
    send(5'd6, 1'b1, 3'd1);
    send(5'd7, 1'b1, 3'd2);
    chk("b2b_busy", 160'(busy_o), 160'h0000_00E0);
    chk("b2b_outstanding", 160'(outstanding_o), 160'd3);
    chk("b2b_q_valid", 160'(acc_q_valid_o), 160'd1);
    tick(2);

    // Q backpressure: held entry stays stable, next request stalls
    acc_q_ready_i = 1'b0;
    send(5'd0, 1'b0, RESV);
    req_valid_i = 1'b1;
    req_wb_i    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_req_ready", 160'(req_ready_o), 160'd0);
      chk("stall_q_hold", q_obs(), q_exp[0]);
      tick(1);
    end
    acc_q_ready_i = 1'b1;
    #1;
    chk("stall_release_ready", 160'(req_ready_o), 160'd1);
    send(5'd3, 1'b0, RESV);

    // out-of-order responses
    wb_ready_i = 1'b1;
    respond(3'd2, 32'hC, 1'b0, 5'd7, 1'b1);
    chk("ooo_wb_valid", 160'(wb_valid_o), 160'd1);
    chk("ooo_busy_a", 160'(busy_o), 160'h0000_00E0);
    respond(3'd0, 32'hA, 1'b0, 5'd5, 1'b1);
    chk("ooo_busy_b", 160'(busy_o), 160'h0000_0060);
    chk("ooo_outstanding_b", 160'(outstanding_o), 160'd2);
    tick(1);
    chk("ooo_busy_c", 160'(busy_o), 160'h0000_0040);
    chk("ooo_outstanding_c", 160'(outstanding_o), 160'd1);
    send(5'd5, 1'b1, 3'd0);
    chk("reuse_busy", 160'(busy_o), 160'h0000_0060);

    // WAW on rd 5
    req_valid_i = 1'b1;
    req_wb_i    = 1'b1;
    req_rd_i    = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("waw_stall", 160'(req_ready_o), 160'd0);
      tick(1);
    end
    respond(3'd0, 32'h55, 1'b0, 5'd5, 1'b1);
    chk("waw_until_wb", 160'(req_ready_o), 160'd0);
    tick(1);
    chk("waw_released", 160'(req_ready_o), 160'd1);
    send(5'd5, 1'b1, 3'd0);

    // fill all IDs
    send(5'd8, 1'b1, 3'd2);
    send(5'd9, 1'b1, 3'd3);
    send(5'd10, 1'b1, 3'd4);
    send(5'd11, 1'b1, 3'd5);
    send(5'd12, 1'b1, 3'd6);
    chk("full_outstanding", 160'(outstanding_o), 160'd7);
    chk("full_busy", 160'(busy_o), 160'h0000_1F60);
    req_valid_i = 1'b1;
    req_wb_i    = 1'b1;
    req_rd_i    = 5'd13;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_stall", 160'(req_ready_o), 160'd0);
      tick(1);
    end
    send(5'd13, 1'b0, RESV);
    respond(RESV, 32'h77, 1'b0, 5'd0, 1'b0);
    chk("resv_stray", 160'(stray_o), 160'd1);
    chk("resv_no_wb", 160'(wb_valid_o), 160'd0);
    tick(1);
    chk("stray_pulse_end", 160'(stray_o), 160'd0);

    // drain to 3 outstanding with a write-back held, then reset
    respond(3'd2, 32'h1000, 1'b0, 5'd8, 1'b1);
    respond(3'd3, 32'h2000, 1'b1, 5'd9, 1'b1);
    respond(3'd4, 32'h3000, 1'b0, 5'd10, 1'b1);
    respond(3'd5, 32'h4000, 1'b0, 5'd11, 1'b1);
    tick(2);
    wb_ready_i = 1'b0;
    respond(3'd6, 32'h5000, 1'b0, 5'd12, 1'b1);
    chk("pre_rst_outstanding", 160'(outstanding_o), 160'd3);
    chk("pre_rst_wb_valid", 160'(wb_valid_o), 160'd1);
    acc_q_ready_i = 1'b0;
    send(5'd0, 1'b0, RESV);
    q_exp.delete();
    wb_exp.delete();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_wb_valid", 160'(wb_valid_o), 160'd0);
    chk("mid_rst_q_valid", 160'(acc_q_valid_o), 160'd0);
    chk("mid_rst_busy", 160'(busy_o), 160'd0);
    chk("mid_rst_outstanding", 160'(outstanding_o), 160'd0);
    chk("mid_rst_wb_data", {122'd0, wb_rd_o, wb_data_o, wb_error_o}, 160'd0);
    chk("mid_rst_q_payload", q_obs(), 160'd0);
    tick(2);
    rst_ni = 1'b1;
    acc_q_ready_i = 1'b1;
    wb_ready_i = 1'b1;
    tick(1);
    respond(3'd1, 32'h99, 1'b0, 5'd6, 1'b0);
    chk("post_rst_stray", 160'(stray_o), 160'd1);
    chk("post_rst_no_wb", 160'(wb_valid_o), 160'd0);
    send(5'd5, 1'b1, 3'd0);
    chk("post_rst_outstanding", 160'(outstanding_o), 160'd1);
    tick(3);
    chk("q_exp_empty", 160'(q_exp.size()), 160'd0);
    chk("wb_exp_empty", 160'(wb_exp.size()), 160'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
